// File: rtl/elevator_car_drive.sv
// elevator_car_drive
//   Car-side motion and door model for the floor controller. A target floor is
//   accepted over a valid/ready handshake while the car is idle. The car then
//   moves one floor every TRAVEL_CYCLES clocks until it reaches the target,
//   opens the door for DOOR_CYCLES clocks and returns to idle.
//
// Optional feature macro: DOOR_OBSTRUCT_EN
//   When defined, the door_obstruct input exists. While it is high in DOOR, the
//   door timer reloads, so the door closes DOOR_CYCLES clocks after the last
//   obstructed cycle. When undefined, the door is open exactly DOOR_CYCLES clocks.
//
// Ports
//   clk            in   rising-edge clock
//   reset          in   asynchronous, active-high reset
//   target_floor   in   commanded floor (FLOOR_W bits)
//   target_valid   in   target_floor is valid
//   target_ready   out  car can accept a target (high only in IDLE)
//   current_floor  out  floor the car is at (registered)
//   moving_up      out  car is travelling upward
//   moving_down    out  car is travelling downward
//   door_open      out  door is open
//   arrived        out  one-cycle pulse in the first DOOR cycle
//   target_err     out  one-cycle pulse after an out-of-range target is rejected
//   door_obstruct  in   keeps the door open (only with DOOR_OBSTRUCT_EN)

module elevator_car_drive #(
  parameter int FLOOR_W       = 6,
  parameter int NUM_FLOORS    = 16,
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES   = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [FLOOR_W-1:0] target_floor,
  input  logic               target_valid,
  output logic               target_ready,
  output logic [FLOOR_W-1:0] current_floor,
  output logic               moving_up,
  output logic               moving_down,
  output logic               door_open,
  output logic               arrived,
  output logic               target_err
`ifdef DOOR_OBSTRUCT_EN
 ,input  logic               door_obstruct
`endif
);

  // Timer widths never drop below one bit, so a cycle count of 1 still works.
  localparam int TW = (TRAVEL_CYCLES > 1) ? $clog2(TRAVEL_CYCLES) : 1;
  localparam int DW = (DOOR_CYCLES > 1) ? $clog2(DOOR_CYCLES) : 1;

  localparam logic [TW-1:0]      TRAVEL_LOAD = TW'(TRAVEL_CYCLES - 1);
  localparam logic [DW-1:0]      DOOR_LOAD   = DW'(DOOR_CYCLES - 1);
  localparam logic [TW-1:0]      TRAVEL_ONE  = TW'(1);
  localparam logic [DW-1:0]      DOOR_ONE    = DW'(1);
  localparam logic [FLOOR_W-1:0] ONE_FLOOR   = FLOOR_W'(1);
  // One bit wider than a floor number so NUM_FLOORS itself is representable.
  localparam logic [FLOOR_W:0]   FLOOR_LIMIT = (FLOOR_W + 1)'(NUM_FLOORS);

  typedef enum logic [1:0] {
    IDLE,
    MOVE_UP,
    MOVE_DOWN,
    DOOR
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [FLOOR_W-1:0] floor_next;
  logic [FLOOR_W-1:0] target_q;
  logic [FLOOR_W-1:0] target_next;
  logic [TW-1:0]      travel_cnt;
  logic [TW-1:0]      travel_next;
  logic [DW-1:0]      door_cnt;
  logic [DW-1:0]      door_next;
  logic               arrived_next;
  logic               err_next;
  logic               hold_door;
  logic               out_of_range;
  logic [FLOOR_W-1:0] floor_above;
  logic [FLOOR_W-1:0] floor_below;

`ifdef DOOR_OBSTRUCT_EN
  assign hold_door = door_obstruct;
`else
  assign hold_door = 1'b0;
`endif

  assign out_of_range = ({1'b0, target_floor} >= FLOOR_LIMIT);
  // Neighbouring floors are only used while moving toward an in-range target,
  // so neither ever wraps.
  assign floor_above  = current_floor + ONE_FLOOR;
  assign floor_below  = current_floor - ONE_FLOOR;

  // State and datapath registers; reset returns the car to floor 0 at once,
  // abandoning any trip or door cycle without an arrived pulse.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      current_floor <= '0;
      target_q      <= '0;
      travel_cnt    <= '0;
      door_cnt      <= '0;
      arrived       <= 1'b0;
      target_err    <= 1'b0;
    end else begin
      state         <= state_next;
      current_floor <= floor_next;
      target_q      <= target_next;
      travel_cnt    <= travel_next;
      door_cnt      <= door_next;
      arrived       <= arrived_next;
      target_err    <= err_next;
    end
  end

  // Next-state logic. arrived and target_err are registered, so each pulse
  // appears in the cycle after the decision, which is the first DOOR cycle
  // for arrived.
  always_comb begin
    state_next   = state;
    floor_next   = current_floor;
    target_next  = target_q;
    travel_next  = travel_cnt;
    door_next    = door_cnt;
    arrived_next = 1'b0;
    err_next     = 1'b0;

    case (state)
      IDLE: begin
        if (target_valid) begin
          if (out_of_range) begin
            err_next = 1'b1;
          end else if (target_floor > current_floor) begin
            target_next = target_floor;
            travel_next = TRAVEL_LOAD;
            state_next  = MOVE_UP;
          end else if (target_floor < current_floor) begin
            target_next = target_floor;
            travel_next = TRAVEL_LOAD;
            state_next  = MOVE_DOWN;
          end else begin
            target_next  = target_floor;
            door_next    = DOOR_LOAD;
            arrived_next = 1'b1;
            state_next   = DOOR;
          end
        end
      end

      MOVE_UP: begin
        if (travel_cnt == '0) begin
          floor_next  = floor_above;
          travel_next = TRAVEL_LOAD;
          if (floor_above == target_q) begin
            door_next    = DOOR_LOAD;
            arrived_next = 1'b1;
            state_next   = DOOR;
          end
        end else begin
          travel_next = travel_cnt - TRAVEL_ONE;
        end
      end

      MOVE_DOWN: begin
        if (travel_cnt == '0) begin
          floor_next  = floor_below;
          travel_next = TRAVEL_LOAD;
          if (floor_below == target_q) begin
            door_next    = DOOR_LOAD;
            arrived_next = 1'b1;
            state_next   = DOOR;
          end
        end else begin
          travel_next = travel_cnt - TRAVEL_ONE;
        end
      end

      DOOR: begin
        // An obstruction restarts the full open period instead of closing.
        if (hold_door) begin
          door_next = DOOR_LOAD;
        end else if (door_cnt == '0) begin
          state_next = IDLE;
        end else begin
          door_next = door_cnt - DOOR_ONE;
        end
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Status outputs are plain decodes of the state register, which keeps
  // them mutually exclusive.
  always_comb begin
    target_ready = (state == IDLE);
    moving_up    = (state == MOVE_UP);
    moving_down  = (state == MOVE_DOWN);
    door_open    = (state == DOOR);
  end

endmodule

// File: tb/tb_elevator_car_drive.sv
// tb_elevator_car_drive
//   Randomized scoreboard bench for elevator_car_drive. Accepted targets are
//   turned into expected events (arrival or rejection, with the cycle they
//   must appear) and an expected trip timeline. A monitor on the falling
//   edge compares the DUT against that timeline and pops events as the DUT
//   pulses arrived or target_err.
//   Define DOOR_OBSTRUCT_EN to also exercise the door obstruction input.

module tb_elevator_car_drive;

  localparam int FLOOR_W    = 6;
  localparam int NUM_FLOORS = 16;
  localparam int TC         = 4;
  localparam int DC         = 8;
  localparam int WAIT_LIMIT = 3000;

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic [FLOOR_W-1:0] target_floor = '0;
  logic               target_valid = 1'b0;
  logic               target_ready;
  logic [FLOOR_W-1:0] current_floor;
  logic               moving_up;
  logic               moving_down;
  logic               door_open;
  logic               arrived;
  logic               target_err;
`ifdef DOOR_OBSTRUCT_EN
  logic               door_obstruct = 1'b0;
`endif

  elevator_car_drive #(
    .FLOOR_W(FLOOR_W),
    .NUM_FLOORS(NUM_FLOORS),
    .TRAVEL_CYCLES(TC),
    .DOOR_CYCLES(DC)
  ) dut (
    .clk(clk),
    .reset(reset),
    .target_floor(target_floor),
    .target_valid(target_valid),
    .target_ready(target_ready),
    .current_floor(current_floor),
    .moving_up(moving_up),
    .moving_down(moving_down),
    .door_open(door_open),
    .arrived(arrived),
    .target_err(target_err)
`ifdef DOOR_OBSTRUCT_EN
   ,.door_obstruct(door_obstruct)
`endif
  );

  always #5 clk = ~clk;

  // Count of rising edges so far; read only on falling edges.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit is_err;
    int floor;
    int cyc;
  } event_t;

  event_t exp_q[$];

  // Reference timeline of the current trip, in rising-edge counts.
  int m_floor    = 0;
  int seg_start  = 0;
  int seg_from   = 0;
  int seg_dir    = 0;
  int seg_arrive = 0;
  int seg_idle   = 0;

  int checks = 0;
  int errors = 0;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s at cycle %0d: got %0d, want %0d", name, cyc, actual, expected);
    end
  endtask

  // Model of one accepted target at rising edge a.
  task automatic model_accept(input int t, input int a);
    event_t e;
    int d;
    seg_start = a;
    seg_from  = m_floor;
    if (t >= NUM_FLOORS) begin
      e.is_err   = 1'b1;
      e.floor    = m_floor;
      e.cyc      = a;
      seg_dir    = 0;
      seg_arrive = a;
      seg_idle   = a;
    end else begin
      d          = (t > m_floor) ? t - m_floor : m_floor - t;
      seg_dir    = (t > m_floor) ? 1 : ((t < m_floor) ? -1 : 0);
      e.is_err   = 1'b0;
      e.floor    = t;
      e.cyc      = a + d * TC;
      seg_arrive = e.cyc;
      seg_idle   = e.cyc + DC;
      m_floor    = t;
    end
    exp_q.push_back(e);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_floor    = 0;
    seg_start  = 0;
    seg_from   = 0;
    seg_dir    = 0;
    seg_arrive = 0;
    seg_idle   = 0;
  endtask

  // Presents target t and holds it until the car accepts it. With noisy set,
  // the inputs carry random garbage while the car is busy, which must be ignored.
  task automatic apply_stimulus(input int t, input bit noisy);
    int waited;
    int a;
    waited = 0;
    @(negedge clk);
    target_floor = FLOOR_W'(t);
    target_valid = 1'b1;
    while (!target_ready && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
      if (noisy && !target_ready) begin
        target_floor = FLOOR_W'($urandom_range(0, 20));
        target_valid = 1'($urandom_range(0, 1));
      end
    end
    if (!target_ready) begin
      check_output("ready_timeout", 0, 1);
      target_valid = 1'b0;
      return;
    end
    target_floor = FLOOR_W'(t);
    target_valid = 1'b1;
    a = cyc + 1;
    @(posedge clk);
    model_accept(t, a);
    #1 target_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int waited;
    waited = 0;
    @(negedge clk);
    while (!target_ready && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (!target_ready) check_output("idle_timeout", 0, 1);
  endtask

  // Monitor: compares outputs with the reference timeline every cycle and
  // pops the scoreboard whenever the DUT presents an event pulse.
  always @(negedge clk) begin
    int exp_floor;
    event_t e;
    if (reset) begin
      check_output("reset_ready", int'(target_ready), 1);
      check_output("reset_floor", int'(current_floor), 0);
      check_output("reset_up", int'(moving_up), 0);
      check_output("reset_down", int'(moving_down), 0);
      check_output("reset_door", int'(door_open), 0);
      check_output("reset_arrived", int'(arrived), 0);
      check_output("reset_err", int'(target_err), 0);
    end else begin
      if (cyc < seg_arrive) exp_floor = seg_from + seg_dir * ((cyc - seg_start) / TC);
      else exp_floor = m_floor;
      check_output("floor", int'(current_floor), exp_floor);
      check_output("ready", int'(target_ready), int'(cyc >= seg_idle));
      check_output("moving_up", int'(moving_up), int'(seg_dir > 0 && cyc < seg_arrive));
      check_output("moving_down", int'(moving_down), int'(seg_dir < 0 && cyc < seg_arrive));
      check_output("door_open", int'(door_open), int'(cyc >= seg_arrive && cyc < seg_idle));
      if (arrived || target_err) begin
        if (exp_q.size() == 0) begin
          check_output("unexpected_event", int'({arrived, target_err}), 0);
        end else begin
          e = exp_q.pop_front();
          check_output("event_kind_err", int'(target_err), int'(e.is_err));
          check_output("event_kind_arr", int'(arrived), int'(!e.is_err));
          check_output("event_cycle", cyc, e.cyc);
          check_output("event_floor", int'(current_floor), e.floor);
        end
      end
      if (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
        e = exp_q.pop_front();
        check_output("missed_event_cycle", cyc, e.cyc);
      end
    end
  end

`ifdef DOOR_OBSTRUCT_EN
  // Obstructs the door for five cycles shortly after arrival.
  task automatic obstruct_test();
    int c;
    int waited;
    apply_stimulus(6, 1'b0);
    waited = 0;
    while (!door_open && waited < WAIT_LIMIT) begin
      @(negedge clk);
      waited++;
    end
    if (!door_open) begin
      check_output("door_timeout", 0, 1);
      return;
    end
    repeat (2) @(negedge clk);
    c = cyc;
    seg_idle = c + 5 + DC;
    door_obstruct = 1'b1;
    repeat (5) @(negedge clk);
    door_obstruct = 1'b0;
    wait_idle();
  endtask
`endif

  initial begin
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;

    $display("[TB] directed trips");
    apply_stimulus(8, 1'b0);
    apply_stimulus(3, 1'b0);
    apply_stimulus(3, 1'b0);
    apply_stimulus(16, 1'b0);
    apply_stimulus(12, 1'b0);
    apply_stimulus(5, 1'b0);
    apply_stimulus(0, 1'b0);
    apply_stimulus(15, 1'b0);
    apply_stimulus(63, 1'b0);
`ifdef DOOR_OBSTRUCT_EN
    obstruct_test();
`endif

    $display("[TB] random trips");
    for (int i = 0; i < 40; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      apply_stimulus(int'($urandom_range(0, 18)), 1'b1);
    end
    wait_idle();
    repeat (3) @(negedge clk);
    check_output("queue_empty", exp_q.size(), 0);

    $display("[TB] reset mid-travel");
    apply_stimulus(int'(m_floor == 10 ? 2 : 10), 1'b0);
    repeat (7) @(posedge clk);
    #2 reset = 1'b1;
    model_reset();
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;
    apply_stimulus(2, 1'b0);
    wait_idle();
    repeat (3) @(negedge clk);
    check_output("queue_empty_end", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
